// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] SEG_OFF    = 8'hFF;

    // Active-high {g,f,e,d,c,b,a} patterns, index 15 listed first.
    localparam logic [15:0][6:0] HEX_PAT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic [3:0] data;
        logic       show;
        logic       dp;
    } digit_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex-to-segment decoder shared by all scanned digits.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    assign pattern = HEX_PAT[value];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin eight-digit seven-segment sequencer with blanking, dp, blink
// and a frame-complete strobe; one decoder is time-shared across digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV   = 4,
    parameter int BLINK_HALF = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_show,
    input  logic       wr_dp,
    input  logic [7:0] blink_mask,
    output logic       frame_done,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic [7:0] seg3,
    output logic [7:0] seg4,
    output logic [7:0] seg5,
    output logic [7:0] seg6,
    output logic [7:0] seg7
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);
    localparam logic [2:0]       PTR_LAST = 3'(NUM_DIGITS - 1);

    digit_t [NUM_DIGITS-1:0]       buffer;
    logic   [NUM_DIGITS-1:0][7:0]  seg_q;
    logic   [DIV_W-1:0]            div;
    logic   [BLK_W-1:0]            blk_cnt;
    logic   [2:0]                  ptr;
    logic                          phase;
    logic                          frame_q;

    logic                          slot;
    digit_t                        cur;
    logic   [6:0]                  pat;
    logic                          blank;
    logic   [7:0]                  seg_next;

    assign slot = (div == DIV_LAST);
    assign cur  = buffer[ptr];

    seg_hex_decoder u_dec (
        .value   (cur.data),
        .pattern (pat)
    );

    // Blink phase is applied only as each digit is refreshed, so a phase
    // flip never glitches a digit between its slots.
    always_comb begin
        blank    = !cur.show || (blink_mask[ptr] && phase);
        seg_next = blank ? SEG_OFF : {~cur.dp, ~pat};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer  <= '0;
            seg_q   <= {NUM_DIGITS{SEG_OFF}};
            div     <= '0;
            blk_cnt <= '0;
            ptr     <= '0;
            phase   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            // The slot reads pre-edge contents; a same-edge write lands a frame later.
            if (wr_en) begin
                buffer[wr_addr] <= '{data: wr_data, show: wr_show, dp: wr_dp};
            end

            div <= slot ? '0 : div + DIV_W'(1);

            if (slot) begin
                seg_q[ptr] <= seg_next;
                ptr        <= ptr + 3'd1;
            end
            frame_q <= slot && (ptr == PTR_LAST);

            if (blk_cnt == BLK_LAST) begin
                blk_cnt <= '0;
                phase   <= ~phase;
            end else begin
                blk_cnt <= blk_cnt + BLK_W'(1);
            end
        end
    end

    assign frame_done = frame_q;
    assign seg0 = seg_q[0];
    assign seg1 = seg_q[1];
    assign seg2 = seg_q[2];
    assign seg3 = seg_q[3];
    assign seg4 = seg_q[4];
    assign seg5 = seg_q[5];
    assign seg6 = seg_q[6];
    assign seg7 = seg_q[7];

endmodule
